pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Three-stage fetch/decode/execute sequencer. Issues fetches, steers ALU
// enables, stalls for the multiplier and flushes on taken branches.
module pipeline_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        cond_pass,
  input  logic        mul_done,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic [31:0] exe_instr,
  output logic        exe_valid,
  output logic        alu_en,
  output logic        mul_start,
  output logic        branch_taken,
  output logic        stall,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MUL_WAIT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_valid;
  logic [31:0] exe_pc;

  logic        is_mul;
  logic        is_branch;
  logic        is_alu;
  logic        in_run;
  logic        issue_mul;
  logic        issue_br;
  logic [31:0] br_target;

  // Fetch handshake: mem_req is the request and mem_ready acknowledges it;
  // a word is consumed only on a cycle where both are high and nothing is issuing.
  assign in_run    = (state == S_RUN);
  assign mem_addr  = pc;
  assign mem_req   = in_run;
  assign stall     = ~in_run;
  assign fsm_state = state;

  assign is_mul    = (exe_instr[27:22] == 6'b000000) && (exe_instr[7:4] == 4'b1001);
  assign is_branch = (exe_instr[27:25] == 3'b101);
  assign is_alu    = (exe_instr[27:26] == 2'b00) && !is_mul;

  assign issue_mul    = in_run && exe_valid && cond_pass && is_mul;
  assign issue_br     = in_run && exe_valid && cond_pass && is_branch;
  assign alu_en       = in_run && exe_valid && cond_pass && is_alu;
  assign mul_start    = issue_mul;
  assign branch_taken = issue_br;

  // Branch offset is a signed word count relative to the instruction PC + 8.
  assign br_target = exe_pc + 32'd8 + {{6{exe_instr[23]}}, exe_instr[23:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      dec_instr <= 32'd0;
      dec_pc    <= 32'd0;
      dec_valid <= 1'b0;
      exe_instr <= 32'd0;
      exe_pc    <= 32'd0;
      exe_valid <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (issue_br) begin
            pc        <= br_target;
            dec_valid <= 1'b0;
            exe_valid <= 1'b0;
            state     <= S_FLUSH;
          end else if (issue_mul) begin
            state <= S_MUL_WAIT;
          end else if (mem_ready) begin
            dec_instr <= mem_rdata;
            dec_pc    <= pc;
            dec_valid <= 1'b1;
            exe_instr <= dec_instr;
            exe_pc    <= dec_pc;
            exe_valid <= dec_valid;
            pc        <= pc + 32'd4;
          end else begin
            exe_instr <= dec_instr;
            exe_pc    <= dec_pc;
            exe_valid <= dec_valid;
            dec_valid <= 1'b0;
          end
        end
        S_MUL_WAIT: begin
          if (mul_done) begin
            exe_valid <= 1'b0;
            state     <= S_RUN;
          end
        end
        S_FLUSH: state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
